// File: rtl/serial_console_pkg.sv
// Shared types and constants for the serial console transmitter.
package serial_console_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre0,
    StPre1,
    StBody,
    StEol
  } state_e;

  localparam logic [7:0] CharLf = 8'h0A;
  localparam logic [7:0] CharSpace = 8'h20;
  localparam int unsigned FrameBits = 10;

endpackage

// File: rtl/serial_console_tx_uart_tx_core.sv
// 8N1 UART transmitter with a built-in baud divider.
module uart_tx_core
  import serial_console_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CntW = $clog2(DIV);

  logic [CntW-1:0] baud_q;
  logic [3:0]      bit_q;
  logic [8:0]      shift_q;
  logic            active_q;
  logic            tx_q;
  logic            bit_end;

  assign bit_end = (baud_q == CntW'(DIV - 1));
  // Ready during the final stop-bit cycle so back-to-back frames have no idle gap.
  assign ready   = !active_q || (bit_end && (bit_q == 4'(FrameBits - 1)));
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else if (load && ready) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, data};
      active_q <= 1'b1;
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q <= '0;
        if (bit_q == 4'(FrameBits - 1)) begin
          active_q <= 1'b0;
        end else begin
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
          bit_q   <= bit_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_console_tx.sv
// UART console output: refreshed line buffer (mode 0) or queued character stream (mode 1).
module serial_console_tx
  import serial_console_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned LINE_LEN   = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  PREFIX0    = 8'h6d,
  parameter logic [7:0]  PREFIX1    = 8'h3a,
  parameter bit          AUTO_WRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       mode,
  input  logic [7:0] char,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       busy,
  output logic       uart_tx
);

  localparam int unsigned Div   = CLK_HZ / BAUD;
  localparam int unsigned LIdxW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned Aw    = $clog2(FIFO_DEPTH);

  state_e      state_q;
  logic        mode_q;
  logic [7:0]  col_q;
  logic [7:0]  idx_q;
  logic [7:0]  wr_idx_q;
  logic [7:0]  line_q [LINE_LEN];
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [Aw:0] wr_ptr_q;
  logic [Aw:0] rd_ptr_q;

  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_head;
  logic       push;
  logic       pop;
  logic       line_wr;
  logic       core_ready;
  logic       load;
  logic [7:0] load_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) &&
                      (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign fifo_head  = fifo_mem_q[rd_ptr_q[Aw-1:0]];

  assign char_ready = mode_q ? !fifo_full : 1'b1;
  assign push       = mode_q && char_valid && !fifo_full;
  assign line_wr    = !mode_q && char_valid;
  assign busy       = (state_q != StIdle) || !core_ready || !fifo_empty;

  always_comb begin
    load      = 1'b0;
    load_data = CharSpace;
    pop       = 1'b0;
    unique case (state_q)
      StPre0: begin
        load      = core_ready;
        load_data = PREFIX0;
      end
      StPre1: begin
        load      = core_ready;
        load_data = PREFIX1;
      end
      StBody: begin
        load = core_ready;
        if (mode_q) begin
          load_data = fifo_head;
          pop       = core_ready;
        end else begin
          load_data = line_q[idx_q[LIdxW-1:0]];
        end
      end
      StEol: begin
        load      = core_ready;
        load_data = CharLf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      col_q   <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          mode_q <= mode;
          idx_q  <= '0;
          if (!mode) begin
            state_q <= StPre0;
          end else begin
            if (!mode_q) col_q <= '0;
            // A fresh entry into stream mode always starts a new line.
            if (!fifo_empty) state_q <= (mode_q && (col_q != 8'd0)) ? StBody : StPre0;
          end
        end
        StPre0: if (load) state_q <= StPre1;
        StPre1: if (load) state_q <= StBody;
        StBody: begin
          if (load) begin
            if (!mode_q) begin
              idx_q <= idx_q + 8'd1;
              if (idx_q == 8'(LINE_LEN - 1)) state_q <= StEol;
            end else if (fifo_head == CharLf) begin
              col_q   <= '0;
              state_q <= StIdle;
            end else begin
              col_q   <= col_q + 8'd1;
              state_q <= (AUTO_WRAP && ((col_q + 8'd1) == 8'(LINE_LEN))) ? StEol : StIdle;
            end
          end
        end
        StEol: begin
          if (load) begin
            col_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < LINE_LEN; i++) line_q[i] <= CharSpace;
      wr_idx_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (line_wr) begin
        line_q[wr_idx_q[LIdxW-1:0]] <= char;
        wr_idx_q <= (wr_idx_q == 8'(LINE_LEN - 1)) ? 8'd0 : wr_idx_q + 8'd1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[Aw-1:0]] <= char;
  end

  uart_tx_core #(
    .DIV(Div)
  ) u_core (
    .clk  (clk),
    .nrst (nrst),
    .data (load_data),
    .load (load),
    .ready(core_ready),
    .tx   (uart_tx)
  );

endmodule

// File: tb/tb_serial_console_tx.sv
// Directed bench: decodes uart_tx back into bytes and compares against hand-computed frames.
module tb_serial_console_tx;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] ch = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       busy;
  logic       uart_tx;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  serial_console_tx #(
    .CLK_HZ    (8),
    .BAUD      (1),
    .LINE_LEN  (4),
    .FIFO_DEPTH(4),
    .PREFIX0   (8'h6d),
    .PREFIX1   (8'h3a),
    .AUTO_WRAP (1'b1)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .mode      (mode),
    .char      (ch),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .busy      (busy),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: mid-bit sampling; stored as {framing_error, byte}.
  logic       rx_on = 1'b0;
  int         rx_cnt = 0;
  int         rx_t0 = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [8:0] rx_q[$];
  int         rx_t[$];

  always @(negedge clk) begin
    if (!nrst) begin
      rx_on <= 1'b0;
    end else if (!rx_on) begin
      if (!uart_tx) begin
        rx_on  <= 1'b1;
        rx_cnt <= 0;
        rx_t0  <= cyc;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == DIV / 2 && uart_tx) rx_on <= 1'b0;
      if (rx_cnt >= 12 && rx_cnt <= 68 && ((rx_cnt - 4) % DIV) == 0) rx_sh <= {uart_tx, rx_sh[7:1]};
      if (rx_cnt == 76) begin
        rx_on <= 1'b0;
        rx_q.push_back({~uart_tx, rx_sh});
        rx_t.push_back(rx_t0);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut(input logic m);
    nrst = 1'b0;
    mode = m;
    char_valid = 1'b0;
    repeat (3) @(negedge clk);
    rx_q.delete();
    rx_t.delete();
    nrst = 1'b1;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k = 0;
    while (rx_q.size() < n && k < n * 100 + 400) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  // Expected bytes packed MSB-first in v, n of them, starting at rx_q[base].
  task automatic expect_bytes(input string tag, input int base, input logic [87:0] v,
                              input int n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s[%0d]", tag, base + i), 32'(rx_q[base + i]),
               {24'd0, 1'b0, v[8 * (n - 1 - i) +: 8]});
    end
  endtask

  task automatic start_latency(input string tag);
    int lat = 0;
    while (uart_tx && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq(tag, 32'(lat >= 1 && lat <= 3), 32'd1);
  endtask

  task automatic send_char(input logic [7:0] c, output logic blocked);
    int k = 0;
    blocked = 1'b0;
    ch = c;
    char_valid = 1'b1;
    while (!char_ready && k < 2000) begin
      blocked = 1'b1;
      @(negedge clk);
      k++;
    end
    check_eq("accept", 32'(char_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic blk;
    logic any_blk;
    int   viol;
    logic [7:0] s2 [5];
    s2[0] = 8'h41; s2[1] = 8'h42; s2[2] = 8'h43; s2[3] = 8'h44; s2[4] = 8'h45;

    // 1: idle line frame repeats
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(char_ready), 32'd1);
    reset_dut(1'b0);
    start_latency("s1_start_lat");
    wait_bytes("s1_wait", 14);
    expect_bytes("s1_f0", 0, {32'd0, 56'h6d3a202020200a}, 7);
    expect_bytes("s1_f1", 7, {32'd0, 56'h6d3a202020200a}, 7);
    for (int i = 0; i < 13; i++) check_eq($sformatf("s1_spacing%0d", i),
                                          32'(rx_t[i + 1] - rx_t[i]), 32'd80);
    check_eq("s1_busy", 32'(busy), 32'd1);

    // 2: line writes wrap to index 0
    reset_dut(1'b0);
    any_blk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_char(s2[i], blk);
      any_blk |= blk;
    end
    char_valid = 1'b0;
    check_eq("s2_never_blocked", 32'(any_blk), 32'd0);
    wait_bytes("s2_wait", 7);
    expect_bytes("s2_frame", 0, {32'd0, 56'h6d3a454243440a}, 7);
    check_eq("s2_ready", 32'(char_ready), 32'd1);

    // 3: stream with explicit LF, then quiet
    reset_dut(1'b1);
    repeat (2) @(negedge clk);
    send_char(8'h68, blk);
    send_char(8'h69, blk);
    send_char(8'h0a, blk);
    char_valid = 1'b0;
    wait_bytes("s3_wait", 5);
    expect_bytes("s3_out", 0, {48'd0, 40'h6d3a68690a}, 5);
    repeat (10) @(negedge clk);
    viol = 0;
    for (int i = 0; i < 500; i++) begin
      if (uart_tx !== 1'b1 || busy !== 1'b0) viol++;
      @(negedge clk);
    end
    check_eq("s3_quiet", 32'(viol), 32'd0);
    check_eq("s3_count", 32'(rx_q.size()), 32'd5);

    // 4: FIFO back-pressure and auto-wrap
    reset_dut(1'b1);
    repeat (2) @(negedge clk);
    any_blk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_char(8'h61 + 8'(i), blk);
      any_blk |= blk;
    end
    char_valid = 1'b0;
    check_eq("s4_backpressure", 32'(any_blk), 32'd1);
    wait_bytes("s4_wait", 11);
    expect_bytes("s4_out", 0, 88'h6d3a61626364_0a6d3a6566, 11);
    repeat (100) @(negedge clk);
    check_eq("s4_count", 32'(rx_q.size()), 32'd11);
    check_eq("s4_idle_busy", 32'(busy), 32'd0);

    // 5: reset mid-byte
    reset_dut(1'b0);
    send_char(8'h5a, blk);
    char_valid = 1'b0;
    wait_bytes("s5_wait", 2);
    while (uart_tx) @(negedge clk);
    repeat (30) @(negedge clk);
    check_eq("s5_pre_tx", 32'(uart_tx), 32'd0);
    nrst = 1'b0;
    @(negedge clk);
    check_eq("s5_tx", 32'(uart_tx), 32'd1);
    check_eq("s5_busy", 32'(busy), 32'd0);
    check_eq("s5_ready", 32'(char_ready), 32'd1);
    reset_dut(1'b0);
    start_latency("s5_start_lat");
    wait_bytes("s5_wait2", 7);
    expect_bytes("s5_frame", 0, {32'd0, 56'h6d3a202020200a}, 7);

    // 6: mode change mid-frame waits for LF
    reset_dut(1'b0);
    wait_bytes("s6_wait", 3);
    mode = 1'b1;
    wait_bytes("s6_wait_lf", 7);
    repeat (200) @(negedge clk);
    expect_bytes("s6_frame", 0, {32'd0, 56'h6d3a202020200a}, 7);
    check_eq("s6_count", 32'(rx_q.size()), 32'd7);
    check_eq("s6_busy", 32'(busy), 32'd0);
    send_char(8'h71, blk);
    char_valid = 1'b0;
    wait_bytes("s6_wait_q", 10);
    expect_bytes("s6_stream", 7, {64'd0, 24'h6d3a71}, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
